// File: rtl/lfsr_burst_ctrl.sv
// lfsr_burst_ctrl: sequencer around a Fibonacci LFSR that hands out bursts of
// pseudo-random words under valid/ready flow control.
//
// A start in IDLE loads the seed (all-zero seed replaced by DEFAULT_SEED) and
// the word count. The LFSR then advances only on accepted words. The block
// pulses done at the end of the burst, and pulses wrap when a transfer brings
// the LFSR back to the seed loaded for this burst.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   start      burst request, sampled only in IDLE
//   seed       initial LFSR state, sampled with start
//   count      words in the burst, sampled with start (0 = empty burst)
//   out_ready  consumer accepts out_data this cycle
//   out_valid  out_data holds a word of the burst
//   out_data   current LFSR state
//   busy       high in RUN and DONE
//   done       one-cycle pulse at burst end
//   seed_fix   one-cycle pulse after a start with an all-zero seed
//   wrap       one-cycle pulse after a transfer that returns LFSR to the seed
module lfsr_burst_ctrl #(
  parameter int unsigned      WIDTH        = 4,
  parameter logic [WIDTH-1:0] TAPS         = 4'b1100,
  parameter logic [WIDTH-1:0] DEFAULT_SEED = 4'b0001,
  parameter int unsigned      CW           = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] seed,
  input  logic [CW-1:0]    count,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             busy,
  output logic             done,
  output logic             seed_fix,
  output logic             wrap
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [CW-1:0] ONE = {{(CW-1){1'b0}}, 1'b1};

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] lfsr_q, lfsr_d;
  logic [WIDTH-1:0] load_seed_q, load_seed_d;
  logic [CW-1:0]    remaining_q, remaining_d;
  logic             seed_fix_q, seed_fix_d;
  logic             wrap_q, wrap_d;

  logic [WIDTH-1:0] lfsr_next;
  logic [WIDTH-1:0] seed_eff;
  logic             xfer;

  assign lfsr_next = {lfsr_q[WIDTH-2:0], ^(lfsr_q & TAPS)};
  // An all-zero state would lock the LFSR, so it is never loaded.
  assign seed_eff  = (seed == '0) ? DEFAULT_SEED : seed;
  assign xfer      = (state_q == RUN) && out_ready;

  always_comb begin
    state_d     = state_q;
    lfsr_d      = lfsr_q;
    load_seed_d = load_seed_q;
    remaining_d = remaining_q;
    seed_fix_d  = 1'b0;
    wrap_d      = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          seed_fix_d = (seed == '0);
          if (count != '0) begin
            lfsr_d      = seed_eff;
            load_seed_d = seed_eff;
            remaining_d = count;
            state_d     = RUN;
          end else begin
            // Empty burst: report completion without touching the LFSR.
            state_d = DONE;
          end
        end
      end
      RUN: begin
        if (xfer) begin
          lfsr_d = lfsr_next;
          wrap_d = (lfsr_next == load_seed_q);
          if (remaining_q != '0) begin
            remaining_d = remaining_q - ONE;
          end
          if (remaining_q == ONE) begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      lfsr_q      <= DEFAULT_SEED;
      load_seed_q <= DEFAULT_SEED;
      remaining_q <= '0;
      seed_fix_q  <= 1'b0;
      wrap_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      lfsr_q      <= lfsr_d;
      load_seed_q <= load_seed_d;
      remaining_q <= remaining_d;
      seed_fix_q  <= seed_fix_d;
      wrap_q      <= wrap_d;
    end
  end

  // All outputs are decodes of registered state, so they are glitch-free and
  // hold steady while the consumer stalls.
  assign out_valid = (state_q == RUN);
  assign busy      = (state_q != IDLE);
  assign done      = (state_q == DONE);
  assign out_data  = lfsr_q;
  assign seed_fix  = seed_fix_q;
  assign wrap      = wrap_q;

endmodule

// File: doc/lfsr_burst_ctrl.md
Name: lfsr_burst_ctrl

Overview:
- Controller that owns a Fibonacci LFSR and hands out bursts of pseudo-random words to a downstream consumer under valid/ready flow control.
- Software or an upstream FSM supplies a seed and a word count, then pulses start. The block loads the seed, repairs the all-zero lock-up seed, and steps the LFSR only when a word is accepted.
- It signals completion and flags when the sequence wraps back to its seed.
- It is the sequencer for the 4-bit LFSR datapath, and is generalised by parameters.

Parameters:
- WIDTH, 4: LFSR and data width.
- TAPS, 4'b1100: feedback mask. Feedback bit = XOR-reduce(state & TAPS). The default gives x^4+x^3+1, which is maximal with period 15.
- DEFAULT_SEED, 4'b0001: substituted when seed == 0. Must be nonzero.
- CW, 8: width of count and of the internal remaining counter.

Ports:
- clk, in, 1: rising-edge clock.
- rst, in, 1: asynchronous, active-high reset.
- start, in, 1: burst request. Sampled only in IDLE.
- seed, in, WIDTH: initial LFSR state. Sampled with start.
- count, in, CW: number of words in the burst. Sampled with start.
- out_ready, in, 1: consumer accepts out_data this cycle.
- out_valid, out, 1: out_data is valid.
- out_data, out, WIDTH: current LFSR state.
- busy, out, 1: high in RUN and DONE.
- done, out, 1: one-cycle pulse at burst end.
- seed_fix, out, 1: one-cycle pulse, the cycle after a start with seed == 0.
- wrap, out, 1: one-cycle pulse when a transfer returns the LFSR state to the burst's loaded seed.

Behaviour:
- Reset (asynchronous, takes effect immediately, including mid-burst):
  - state = IDLE.
  - lfsr = DEFAULT_SEED.
  - remaining = 0.
  - out_valid, busy, done, seed_fix and wrap all = 0.
  - out_data = DEFAULT_SEED.
- Transfer: out_valid && out_ready at a rising edge.
- Next LFSR value: {lfsr[WIDTH-2:0], ^(lfsr & TAPS)}.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - On start && count != 0, at that edge:
    - lfsr <= (seed == 0 ? DEFAULT_SEED : seed).
    - load_seed <= the same value.
    - remaining <= count.
    - seed_fix <= (seed == 0).
    - Go to RUN.
  - On start && count == 0: go to DONE. lfsr is unchanged. seed_fix is still reported.
  - Latency: out_valid rises the cycle after start is sampled.
- RUN:
  - out_valid = 1 and out_data = lfsr. Both are registered and stable while out_ready = 0.
  - On a transfer:
    - lfsr <= next.
    - remaining <= remaining - 1.
    - wrap pulses the next cycle if next == load_seed.
  - A transfer with remaining == 1 goes to DONE.
  - The first word emitted is the loaded seed.
- DONE: out_valid = 0, done = 1 for exactly one cycle, then go to IDLE. busy falls in IDLE.
- start is ignored while busy. There is no queuing.
- lfsr keeps its final value in IDLE. out_data shows lfsr but is meaningful only with out_valid.
- remaining never underflows. count is the maximum 2^CW-1 without overflow.
- out_ready high in IDLE or DONE has no effect.
- Simultaneous start and reset: reset wins.

Test Plan:
- Reset values: assert rst for 10 ns at t = 0 -> all outputs 0 and out_data = 0001. Drop rst with start = 0 -> outputs remain idle with no pulses.
- Full period: seed = 0001, count = 15, out_ready = 1 -> out_valid for exactly 15 cycles, starting the cycle after start.
  - Required words: 0001, 0010, 0100, 1001, 0011, 0110, 1101, 1010, 0101, 1011, 0111, 1111, 1110, 1100, 1000.
  - wrap pulses after the 15th transfer, done pulses once, busy then falls.
- Lock-up repair: seed = 0000, count = 3 -> seed_fix pulses once. Words are 0001, 0010, 0100, then done.
- Backpressure: seed = 1010, count = 4, with out_ready toggled 1, 0, 0, 1, 1, 0, 1 -> accepted sequence 1010, 0101, 1011, 0111. out_data holds steady during the low-ready cycles. done comes only after the 4th acceptance.
- Degenerate and ignored start:
  - count = 0 -> no out_valid, done pulses the cycle after start.
  - A second start with seed = 1111 during a burst -> no effect, and the sequence continues unchanged.
- Reset mid-burst: assert rst after the 2nd transfer of a count = 10 burst -> out_valid and busy drop immediately, with no done pulse. A fresh start afterwards behaves normally from its new seed.
